// File: rtl/vref_monitor.sv
// vref_monitor: powers the 5V reference, qualifies it through the window
// comparators, watches it while in use and latches/counts faults.
module vref_monitor #(
    parameter int DEBOUNCE     = 16,
    parameter int RAMP_TIMEOUT = 1024
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       enable_i,
    input  logic       cmp_lo_i,
    input  logic       cmp_hi_i,
    input  logic       clr_fault_i,
    output logic       ref_en_o,
    output logic       ref_good_o,
    output logic       fault_o,
    output logic [1:0] fault_code_o,
    output logic [7:0] fault_cnt_o,
    output logic [1:0] state_o
);

    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int TW = (RAMP_TIMEOUT > 1) ? $clog2(RAMP_TIMEOUT) : 1;

    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(RAMP_TIMEOUT - 1);

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_TMO  = 2'b01;
    localparam logic [1:0] CODE_UV   = 2'b10;
    localparam logic [1:0] CODE_OV   = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RAMP  = 2'b01,
        GOOD  = 2'b10,
        FAULT = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [1:0]    code_q, code_d;
    logic [7:0]    fcnt_q, fcnt_d;
    logic          ref_en_q, ref_good_q, fault_q;
    logic          lo_s1_q, lo_s2_q, hi_s1_q, hi_s2_q;
    logic          in_range;

    // Two-flop synchronizers for the asynchronous comparator outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lo_s1_q <= 1'b0;
            lo_s2_q <= 1'b0;
            hi_s1_q <= 1'b0;
            hi_s2_q <= 1'b0;
        end else begin
            lo_s1_q <= cmp_lo_i;
            lo_s2_q <= lo_s1_q;
            hi_s1_q <= cmp_hi_i;
            hi_s2_q <= hi_s1_q;
        end
    end

    assign in_range = lo_s2_q & ~hi_s2_q;

    // Next-state logic: counters default to zero so every state change restarts them.
    // RAMP qualifies on the edge after the DEBOUNCE-th good sample; GOOD faults on
    // the edge of the DEBOUNCE-th bad sample so the code reflects that sample.
    always_comb begin
        state_d = state_q;
        deb_d   = '0;
        tmr_d   = '0;
        code_d  = code_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = RAMP;
                end
            end
            RAMP: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (deb_q == DEB_MAX) begin
                    state_d = GOOD;
                end else if (tmr_q == TMO_LAST) begin
                    state_d = FAULT;
                    code_d  = CODE_TMO;
                end else begin
                    deb_d = in_range ? deb_q + 1'b1 : '0;
                    tmr_d = tmr_q + 1'b1;
                end
            end
            GOOD: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (!in_range) begin
                    if (deb_q == DEB_LAST) begin
                        state_d = FAULT;
                        code_d  = hi_s2_q ? CODE_OV : CODE_UV;
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end
            end
            FAULT: begin
                if (clr_fault_i) begin
                    state_d = IDLE;
                    code_d  = CODE_NONE;
                end
            end
            default: state_d = IDLE;
        endcase
        if ((state_d == FAULT) && (state_q != FAULT) && (fcnt_q != 8'hFF)) begin
            fcnt_d = fcnt_q + 8'd1;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            deb_q      <= '0;
            tmr_q      <= '0;
            code_q     <= CODE_NONE;
            fcnt_q     <= 8'd0;
            ref_en_q   <= 1'b0;
            ref_good_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            deb_q      <= deb_d;
            tmr_q      <= tmr_d;
            code_q     <= code_d;
            fcnt_q     <= fcnt_d;
            ref_en_q   <= (state_d == RAMP) || (state_d == GOOD);
            ref_good_q <= (state_d == GOOD);
            fault_q    <= (state_d == FAULT);
        end
    end

    assign ref_en_o     = ref_en_q;
    assign ref_good_o   = ref_good_q;
    assign fault_o      = fault_q;
    assign fault_code_o = code_q;
    assign fault_cnt_o  = fcnt_q;
    assign state_o      = state_q;

endmodule

// File: doc/vref_monitor.md
VREF_MONITOR -- requirements
Module: vref_monitor

Interface
REQ-001 Parameter DEBOUNCE, default 16: consecutive synchronized samples needed to qualify the reference as good or as failed.
REQ-002 Parameter RAMP_TIMEOUT, default 1024: maximum number of cycles spent in RAMP before a timeout fault.
REQ-003 CLK  in  1  single clock; all state changes on its rising edge.
REQ-004 RST_N  in  1  reset, asynchronous, active-low.
REQ-005 ENABLE  in  1  request to power and qualify the 5V reference.
REQ-006 CMP_LO  in  1  asynchronous comparator output; 1 = VOUT above the low threshold.
REQ-007 CMP_HI  in  1  asynchronous comparator output; 1 = VOUT above the high threshold.
REQ-008 CLR_FAULT  in  1  clears a latched fault.
REQ-009 REF_EN  out  1  drives the reference VIN switch.
REQ-010 REF_GOOD  out  1  reference qualified and within its window.
REQ-011 FAULT  out  1  fault latched.
REQ-012 FAULT_CODE  out  2  00 none, 01 ramp timeout, 10 undervoltage, 11 overvoltage.
REQ-013 FAULT_CNT  out  8  number of fault entries since reset; saturates at 255.
REQ-014 STATE  out  2  00 IDLE, 01 RAMP, 10 GOOD, 11 FAULT.

Function
REQ-015 CMP_LO and CMP_HI SHALL each pass through a 2-flop synchronizer, and only the synchronized values SHALL be used.
REQ-016 in_range SHALL be defined as sync CMP_LO = 1 and sync CMP_HI = 0.
REQ-017 All outputs SHALL be registered.
REQ-018 REF_EN SHALL be 1 in RAMP and GOOD, and 0 otherwise.
REQ-019 REF_GOOD SHALL be 1 only in GOOD.
REQ-020 FAULT SHALL be 1 only in FAULT.
REQ-021 IDLE behaviour:
- ENABLE = 1 -> RAMP.
- On entry, clear the debounce counter and the ramp timer.
REQ-022 RAMP debounce:
- Counter increments on each cycle with in_range = 1.
- Counter clears on any cycle with in_range = 0.
- After DEBOUNCE consecutive in_range samples -> GOOD on the next edge.
REQ-023 RAMP timeout:
- Timer counts cycles spent in RAMP.
- When RAMP_TIMEOUT cycles have elapsed without qualification -> FAULT, code 01.
REQ-024 In RAMP, if debounce completion and timeout occur in the same cycle, GOOD SHALL win.
REQ-025 GOOD monitoring:
- Debounce counter restarts on entry.
- Counter counts consecutive cycles with in_range = 0.
- After DEBOUNCE such cycles -> FAULT.
- Code 11 if sync CMP_HI = 1 in the terminal cycle, otherwise code 10 (CMP_HI takes priority over CMP_LO).
REQ-026 In GOOD, a single in_range = 1 sample SHALL clear the out-of-range count (glitch rejection).
REQ-027 ENABLE = 0 in RAMP or GOOD SHALL move the FSM to IDLE on the next edge, with no fault recorded, even if a fault condition occurs in the same cycle.
REQ-028 FAULT SHALL be held until CLR_FAULT = 1, regardless of ENABLE; CLR_FAULT then moves the FSM to IDLE and sets FAULT_CODE to 00.
REQ-029 CLR_FAULT SHALL be ignored outside FAULT.
REQ-030 FAULT_CODE SHALL hold its value from FAULT entry until cleared.
REQ-031 FAULT_CNT SHALL increment by 1 on each transition into FAULT, hold at 255 (no wrap), and be cleared only by reset.
REQ-032 Counter widths SHALL be sized with clog2 of their parameter, and counters SHALL saturate rather than wrap.

Reset
REQ-033 While RST_N = 0, and immediately on its assertion, all of the following SHALL hold:
- STATE = IDLE.
- REF_EN, REF_GOOD, FAULT = 0.
- FAULT_CODE = 00, FAULT_CNT = 0.
- Synchronizers, counters and timer cleared.
REQ-034 Reset asserted mid-RAMP or mid-GOOD SHALL drop REF_EN with no fault recorded.
REQ-035 After RST_N rises, the FSM SHALL leave IDLE no earlier than the first rising edge at which ENABLE = 1.

Verification (DEBOUNCE = 4, RAMP_TIMEOUT = 32)
REQ-036 ENABLE = 1, CMP_LO = 1, CMP_HI = 0 from the first cycle -> REF_EN = 1 one edge later, REF_GOOD = 1 exactly 6 edges (DEBOUNCE + 2) after the first in_range sample, FAULT_CNT = 0.
REQ-037 ENABLE = 1, CMP_LO = 0 held -> FAULT = 1 and FAULT_CODE = 01 after 32 RAMP cycles, REF_EN = 0, FAULT_CNT = 1; CLR_FAULT pulse -> IDLE with FAULT_CODE = 00.
REQ-038 GOOD, then CMP_LO low for 3 cycles, then high -> state stays GOOD; CMP_LO low for 4 or more cycles -> FAULT_CODE = 10; CMP_HI high for 4 or more cycles -> FAULT_CODE = 11.
REQ-039 GOOD, then ENABLE = 0 in the same cycle the 4th out-of-range sample completes -> IDLE, FAULT = 0, FAULT_CNT unchanged.
REQ-040 Force 260 timeout faults, each cleared by CLR_FAULT -> FAULT_CNT = 255 at the end.
REQ-041 Pulse RST_N low mid-RAMP -> REF_EN = 0 asynchronously, all outputs at their reset values, and STATE = RAMP one edge after RST_N rises with ENABLE = 1.
